// File: rtl/wb_sdram_bridge.sv
// Wishbone slave front end for the SDRAM controller.
// Turns Wishbone beats into FIFO pushes/pops and controller command levels.
module wb_sdram_bridge #(
  parameter logic [31:0] ADDR_OFFSET  = 32'h0,
  parameter int unsigned READ_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wbs_cyc,
  input  logic        i_wbs_stb,
  input  logic        i_wbs_we,
  input  logic [3:0]  i_wbs_sel,
  input  logic [31:0] i_wbs_adr,
  input  logic [31:0] i_wbs_dat,
  output logic [31:0] o_wbs_dat,
  output logic        o_wbs_ack,
  output logic        o_wbs_int,
  output logic        wr_fifo_wr,
  output logic [31:0] wr_fifo_data,
  output logic [3:0]  wr_fifo_mask,
  input  logic        wr_fifo_full,
  output logic        rd_fifo_rd,
  input  logic [31:0] rd_fifo_data,
  input  logic        rd_fifo_empty,
  output logic        rd_fifo_reset,
  output logic        write_en,
  output logic        read_en,
  output logic [21:0] address,
  input  logic        sdram_ready
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_ACK, WR_HOLD, RD_REQ, RD_CAP, RD_ACK
  } state_t;

  localparam int CW = $clog2(READ_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(READ_TIMEOUT - 1);
  localparam logic [31:0] CLR_ADR = ADDR_OFFSET + 32'h003F_FFFF;

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic          rd_acked;
  logic          req;
  logic          timeout;
  logic [21:0]   adr_map;

  assign req     = i_wbs_cyc & i_wbs_stb & sdram_ready;
  assign adr_map = 22'(i_wbs_adr - ADDR_OFFSET);

  assign wr_fifo_data = wr_fifo_wr ? i_wbs_dat : 32'h0;
  assign wr_fifo_mask = wr_fifo_wr ? ~i_wbs_sel : 4'h0;

  always_comb begin
    next          = state;
    wr_fifo_wr    = 1'b0;
    rd_fifo_rd    = 1'b0;
    rd_fifo_reset = 1'b0;
    o_wbs_ack     = 1'b0;
    write_en      = 1'b0;
    read_en       = 1'b0;
    timeout       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (i_wbs_we) begin
            next = WR;
          end else begin
            rd_fifo_reset = 1'b1;
            next          = RD_REQ;
          end
        end
      end
      WR: begin
        write_en = 1'b1;
        if (i_wbs_stb && sdram_ready && !wr_fifo_full) begin
          wr_fifo_wr = 1'b1;
          next       = WR_ACK;
        end
      end
      WR_ACK: begin
        write_en  = 1'b1;
        o_wbs_ack = 1'b1;
        next      = WR_HOLD;
      end
      WR_HOLD: begin
        write_en = 1'b1;
        if (!i_wbs_stb) next = WR;
      end
      RD_REQ: begin
        read_en = 1'b1;
        if (i_wbs_stb && sdram_ready && !rd_fifo_empty) begin
          rd_fifo_rd = 1'b1;
          next       = RD_CAP;
        end else if (cnt == TO_LAST) begin
          timeout = 1'b1;
          next    = RD_ACK;
        end
      end
      RD_CAP: begin
        read_en = 1'b1;
        next    = RD_ACK;
      end
      RD_ACK: begin
        read_en   = 1'b1;
        o_wbs_ack = !rd_acked;
        if (!i_wbs_stb) next = RD_REQ;
      end
      default: next = IDLE;
    endcase
    // an abandoned cycle must not complete any beat
    if (!i_wbs_cyc) begin
      next       = IDLE;
      wr_fifo_wr = 1'b0;
      rd_fifo_rd = 1'b0;
      o_wbs_ack  = 1'b0;
      timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_acked  <= 1'b0;
      address   <= 22'h0;
      o_wbs_dat <= 32'h0;
      o_wbs_int <= 1'b0;
    end else begin
      state    <= next;
      rd_acked <= (state == RD_ACK);
      if (state == IDLE && req) address <= adr_map;
      if (state == RD_REQ) cnt <= cnt + CW'(1);
      else cnt <= '0;
      if (state == RD_CAP) o_wbs_dat <= rd_fifo_data;
      else if (timeout) o_wbs_dat <= 32'h0;
      if (timeout) o_wbs_int <= 1'b1;
      else if (wr_fifo_wr && i_wbs_adr == CLR_ADR) o_wbs_int <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Scoreboard bench for wb_sdram_bridge with a simple SDRAM controller model.
// Expected pushes/acks are queued by stimulus and popped by a monitor.
module tb_wb_sdram_bridge;

  localparam logic [31:0] OFS = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wbs_cyc = 1'b0;
  logic        i_wbs_stb = 1'b0;
  logic        i_wbs_we = 1'b0;
  logic [3:0]  i_wbs_sel = 4'h0;
  logic [31:0] i_wbs_adr = 32'h0;
  logic [31:0] i_wbs_dat = 32'h0;
  logic [31:0] o_wbs_dat;
  logic        o_wbs_ack;
  logic        o_wbs_int;
  logic        wr_fifo_wr;
  logic [31:0] wr_fifo_data;
  logic [3:0]  wr_fifo_mask;
  logic        wr_fifo_full;
  logic        rd_fifo_rd;
  logic [31:0] rd_fifo_data;
  logic        rd_fifo_empty;
  logic        rd_fifo_reset;
  logic        write_en;
  logic        read_en;
  logic [21:0] address;
  logic        sdram_ready;

  wb_sdram_bridge #(.ADDR_OFFSET(OFS), .READ_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
    .i_wbs_sel(i_wbs_sel), .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
    .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack), .o_wbs_int(o_wbs_int),
    .wr_fifo_wr(wr_fifo_wr), .wr_fifo_data(wr_fifo_data),
    .wr_fifo_mask(wr_fifo_mask), .wr_fifo_full(wr_fifo_full),
    .rd_fifo_rd(rd_fifo_rd), .rd_fifo_data(rd_fifo_data),
    .rd_fifo_empty(rd_fifo_empty), .rd_fifo_reset(rd_fifo_reset),
    .write_en(write_en), .read_en(read_en), .address(address),
    .sdram_ready(sdram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  mask;
  } push_t;

  typedef struct {
    bit          rd;
    bit          to;
    logic [31:0] dat;
    logic [21:0] adr;
    bit          intr;
  } ack_t;

  push_t pq[$];
  ack_t  aq[$];

  int n_checks = 0;
  int n_err = 0;
  int tcyc = 0;
  int full_until = 0;
  int ready_at = 0;
  int rd_lat = 3;
  bit stuck_empty = 1'b0;
  bit m_int = 1'b0;
  int pushes = 0;
  int pops = 0;
  int rst_pulses = 0;

  always @(posedge clk) tcyc <= tcyc + 1;
  assign wr_fifo_full = (tcyc < full_until);
  assign sdram_ready  = (tcyc >= ready_at);

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // controller model: streams mem_word(address+i) into a small read FIFO
  logic [31:0] rdq[$];
  logic [21:0] fidx;
  int          wait_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdq.delete();
      fidx = 22'h0;
      wait_cnt = 0;
      rd_fifo_empty <= 1'b1;
      rd_fifo_data  <= 32'h0;
    end else begin
      if (rd_fifo_rd && rdq.size() > 0) rd_fifo_data <= rdq.pop_front();
      if (rd_fifo_reset) begin
        rdq.delete();
        fidx = 22'h0;
        wait_cnt = 0;
      end else if (read_en && !stuck_empty) begin
        if (wait_cnt < rd_lat) wait_cnt++;
        else if (rdq.size() < 2) begin
          rdq.push_back(mem_word(address + fidx));
          fidx = fidx + 22'h1;
        end
      end
      rd_fifo_empty <= (rdq.size() == 0);
    end
  end

  int  cyc_n = 0;
  int  rst_cyc = -10;
  int  push_cyc = -10;
  int  rd_cyc = -10;
  bit  prev_ack = 1'b0;
  bit  prev_ren = 1'b0;

  always @(negedge clk) begin
    push_t p;
    ack_t  a;
    cyc_n++;
    if (!rst) begin
      if (rd_fifo_reset) begin
        rst_pulses++;
        chk("flush_before_read_en", read_en, 0);
        rst_cyc = cyc_n;
      end
      if (read_en && !prev_ren) chk("read_en_after_flush", cyc_n - rst_cyc, 1);
      if (wr_fifo_wr) begin
        pushes++;
        chk("push_not_full", wr_fifo_full, 0);
        chk("push_expected", 32'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk("push_data", wr_fifo_data, p.dat);
          chk("push_mask", wr_fifo_mask, p.mask);
        end
        push_cyc = cyc_n;
      end
      if (rd_fifo_rd) begin
        pops++;
        rd_cyc = cyc_n;
      end
      if (o_wbs_ack) begin
        chk("ack_one_cycle", prev_ack, 0);
        chk("ack_expected", 32'(aq.size() > 0), 1);
        if (aq.size() > 0) begin
          a = aq.pop_front();
          chk("ack_address", address, a.adr);
          chk("ack_int", o_wbs_int, a.intr);
          if (a.rd) chk("ack_rdata", o_wbs_dat, a.dat);
          if (a.rd && !a.to) chk("rd_pop_to_ack", cyc_n - rd_cyc, 2);
          if (!a.rd) chk("wr_push_to_ack", cyc_n - push_cyc, 1);
        end
      end
    end
    prev_ack = o_wbs_ack;
    prev_ren = read_en;
  end

  task automatic do_cycle(input bit we, input logic [31:0] adr, input int nb,
                          input logic [31:0] dat0, input logic [3:0] sel0,
                          input int full_beat, input int full_len,
                          input bit exp_to, output int lat0);
    logic [21:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    a = 22'(adr - OFS);
    lat0 = 0;
    for (int k = 0; k < nb; k++) begin
      d = (k == 0) ? dat0 : $urandom;
      s = (k == 0) ? sel0 : 4'($urandom);
      if (we) begin
        pq.push_back(push_t'{d, ~s});
        if (adr + 32'(k) == OFS + 32'h003F_FFFF) m_int = 1'b0;
        aq.push_back(ack_t'{1'b0, 1'b0, 32'h0, a, m_int});
      end else if (exp_to) begin
        m_int = 1'b1;
        aq.push_back(ack_t'{1'b1, 1'b1, 32'h0, a, 1'b1});
      end else begin
        aq.push_back(ack_t'{1'b1, 1'b0, mem_word(a + 22'(k)), a, m_int});
      end
      i_wbs_we  = we;
      i_wbs_adr = adr + 32'(k);
      i_wbs_dat = d;
      i_wbs_sel = s;
      i_wbs_cyc = 1'b1;
      i_wbs_stb = 1'b1;
      if (k == full_beat) full_until = tcyc + full_len;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!o_wbs_ack && lat < 200);
      chk("beat_acked", o_wbs_ack, 1);
      if (k == 0) lat0 = lat;
      @(posedge clk);
      #1 i_wbs_stb = 1'b0;
      if (k == nb - 1) i_wbs_cyc = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("write_en_low_after_cyc", write_en, 0);
    chk("read_en_low_after_cyc", read_en, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int p0;
    int r0;
    int fb;
    int nb;
    bit we;
    repeat (3) @(negedge clk);
    chk("outputs_zero_in_reset",
        |{o_wbs_dat, o_wbs_ack, o_wbs_int, wr_fifo_wr, wr_fifo_data,
          wr_fifo_mask, rd_fifo_rd, rd_fifo_reset, write_en, read_en,
          address}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_cycle(1, 32'h10, 1, 32'hA5A5_1234, 4'b0011, 99, 0, 0, lat);
    chk("single_write_latency", lat, 3);

    p0 = pushes;
    do_cycle(1, 32'h200, 4, $urandom, 4'hF, 1, 5, 0, lat);
    chk("burst_push_count", pushes - p0, 4);

    rd_lat = 7;
    p0 = pops;
    r0 = rst_pulses;
    do_cycle(0, 32'h0, 1, 32'h0, 4'h0, 99, 0, 0, lat);
    chk("single_read_pops", pops - p0, 1);
    chk("single_read_flushes", rst_pulses - r0, 1);

    stuck_empty = 1'b1;
    do_cycle(0, 32'h80, 1, 32'h0, 4'h0, 99, 0, 1, lat);
    chk("timeout_latency", lat, 18);
    chk("int_set_after_timeout", o_wbs_int, 1);
    stuck_empty = 1'b0;
    do_cycle(1, 32'h003F_FFFF, 1, $urandom, 4'hF, 99, 0, 0, lat);
    chk("int_cleared", o_wbs_int, 0);

    ready_at = tcyc + 20;
    do_cycle(1, 32'h1234, 1, $urandom, 4'h5, 99, 0, 0, lat);
    chk("ready_stall_latency", lat, 23);

    // abandon a read while it waits on the FIFO
    stuck_empty = 1'b1;
    r0 = rst_pulses;
    i_wbs_we  = 1'b0;
    i_wbs_adr = 32'h40;
    i_wbs_cyc = 1'b1;
    i_wbs_stb = 1'b1;
    repeat (4) @(posedge clk);
    #1 i_wbs_cyc = 1'b0;
    i_wbs_stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cyc_drop_read_en", read_en, 0);
    chk("cyc_drop_no_ack", o_wbs_ack, 0);
    chk("cyc_drop_flush", rst_pulses - r0, 1);
    stuck_empty = 1'b0;
    rd_lat = 2;
    @(posedge clk);
    #1;
    do_cycle(0, 32'h55, 2, 32'h0, 4'h0, 99, 0, 0, lat);

    // reset while the write ack is due
    pq.push_back(push_t'{32'hCAFE_0001, 4'b0000});
    i_wbs_we  = 1'b1;
    i_wbs_adr = 32'h300;
    i_wbs_dat = 32'hCAFE_0001;
    i_wbs_sel = 4'hF;
    i_wbs_cyc = 1'b1;
    i_wbs_stb = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    i_wbs_cyc = 1'b0;
    i_wbs_stb = 1'b0;
    m_int = 1'b0;
    @(negedge clk);
    chk("rst_mid_beat_outputs",
        |{o_wbs_ack, write_en, read_en, wr_fifo_wr, address, o_wbs_int}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(0, 32'h777, 1, 32'h0, 4'h0, 99, 0, 0, lat);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      fb = $urandom_range(0, nb);
      rd_lat = $urandom_range(0, 8);
      do_cycle(we, $urandom, nb, $urandom, 4'($urandom), fb,
               $urandom_range(1, 4), 0, lat);
      if (we && fb != 0) chk("rand_write_latency", lat, 3);
    end

    repeat (4) @(posedge clk);
    chk("push_queue_drained", pq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
